control_seq: RTL
================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter OP_W, default 7, opcode width; opcode fields below use bits [6:0], upper bits SHALL be zero for a legal opcode.
REQ-002 Parameter TPU_DIM, default 8, rows per TPU matrix load burst (power of 2, >=2).
REQ-003 Parameter TMO_W, default 8, TPU done-timeout counter width.
REQ-004 Ports SHALL be:
  clk_i  in  1  clock, rising edge;
  rst_i  in  1  reset, asynchronous, active-high;
  valid_i  in  1  opcode valid;
  op_i  in  OP_W  opcode;
  ready_o  out  1  block accepts opcode this cycle;
  stall_i  in  1  downstream hold;
  flush_i  in  1  discard pending/issued decode;
  tpu_done_i  in  1  TPU matmul complete;
  valid_o  out  1  registered decode valid;
  imm_sel_o  out  1;  alu_op_o  out  4;  branch_type_o  out  2;  wb_sel_o  out  2;
  reg_write_enable_o, mem_write_enable_o, tpu_start_o  out  1 each;
  tpu_write_enable_A/B/C  out  1 each;
  tpu_row_o  out  $clog2(TPU_DIM)  burst row index;
  tpu_busy_o  out  1  state != IDLE;
  tpu_timeout_o  out  1  sticky timeout flag.

Function
REQ-005 Decode SHALL keep the existing encoding: ALU ops 0x01-0x0A, imm ALU 0x11,0x13-0x19,0x1B, lw 0x20, sw 0x21, branches 0x3C-0x3F, matmul 0x50, lam 0x51, lbm 0x52, lacc 0x53, racc 0x54, j 0x7E, jr 0x7F; all else NOP.
REQ-006 Field rules SHALL be unchanged: imm_sel=op[4]^op[5]; wb_sel[0]=op[6:4]==010; wb_sel[1]=op[6:4]==101; alu_op=4'h1 if wb_sel[0] else op[3:0]; branch_type=01 for op[6:4]==011, {1,op[0]} for op[6:1] all ones, else 00.
REQ-007 Handshake: opcode accepted when valid_i & ready_o; ready_o = state==IDLE & ~stall_i.
REQ-008 Decode outputs SHALL be registered: accepted opcode appears with valid_o=1 exactly one cycle later (latency 1).
REQ-009 When stall_i=1 and valid_o=1, all decode outputs SHALL hold; no enable re-pulses.
REQ-010 reg_write_enable_o, mem_write_enable_o, tpu_start_o SHALL be qualified by valid_o (zero when valid_o=0).
REQ-011 FSM states IDLE, BURST, WAIT_DONE.
REQ-012 IDLE: accepted lam/lbm/lacc -> BURST; accepted matmul -> WAIT_DONE; others stay IDLE.
REQ-013 BURST: matching tpu_write_enable_X SHALL pulse once per non-stalled cycle for TPU_DIM cycles, tpu_row_o = 0..TPU_DIM-1, first pulse coincident with valid_o; stall_i freezes row and deasserts enable; after row TPU_DIM-1 -> IDLE.
REQ-014 WAIT_DONE: tpu_start_o SHALL be high exactly one cycle (with valid_o); then wait for tpu_done_i -> IDLE; tpu_done_i in the start cycle SHALL be ignored.
REQ-015 racc SHALL be accepted only in IDLE (guaranteed by ready_o); no TPU state change.
REQ-016 flush_i: clears valid_o next cycle; input same cycle dropped; BURST aborts to IDLE with row reset to 0; WAIT_DONE unaffected (TPU already started).
REQ-017 tpu_done_i in IDLE/BURST SHALL be ignored.

Reset
REQ-018 rst_i asserted SHALL immediately force state IDLE, valid_o=0, all enables 0, tpu_row_o=0, timeout counter 0, tpu_timeout_o=0, decode fields 0, regardless of clock.
REQ-019 Reset mid-BURST or mid-WAIT_DONE SHALL abandon the operation; no further enables after deassertion.

Configuration
REQ-020 Macro CONTROL_SEQ_TIMEOUT_EN defined: TMO_W counter runs in WAIT_DONE; at all-ones without tpu_done_i -> IDLE and tpu_timeout_o sets, sticky until reset.
REQ-021 Macro undefined: WAIT_DONE waits indefinitely; tpu_timeout_o tied 0; no counter logic.

Verification
REQ-022 add 0x01 accepted -> next cycle valid_o=1, reg_write_enable_o=1, alu_op_o=1, wb_sel_o=00.
REQ-023 lbm 0x52, TPU_DIM=8, stall_i=1 one cycle at row 3 -> 8 write_enable_B pulses, rows 0-7, 9 cycles, ready_o low throughout.
REQ-024 matmul 0x50, tpu_done_i 5 cycles later -> one tpu_start_o pulse, tpu_busy_o high 5 cycles, then ready_o=1.
REQ-025 TIMEOUT_EN, TMO_W=4, no done -> return to IDLE after 15 wait cycles, tpu_timeout_o=1 sticky.
REQ-026 flush_i at row 2 of lam 0x51 -> enable_A stops, tpu_row_o=0, IDLE next cycle.
REQ-027 rst_i async pulse mid-BURST -> outputs zero before next clock edge.

Source files
------------

// File: rtl/control_seq_if.sv
// control_seq_if: opcode handshake, decode outputs and TPU sequencing signals
// shared between the control_seq decode stage and whatever drives/consumes it.

interface control_seq_if #(
  parameter int OP_W    = 7,
  parameter int TPU_DIM = 8
);
  localparam int ROW_W = $clog2(TPU_DIM);

  // Opcode handshake and pipeline control
  logic             valid_i;
  logic [OP_W-1:0]  op_i;
  logic             ready_o;
  logic             stall_i;
  logic             flush_i;
  logic             tpu_done_i;

  // Registered decode
  logic             valid_o;
  logic             imm_sel_o;
  logic [3:0]       alu_op_o;
  logic [1:0]       branch_type_o;
  logic [1:0]       wb_sel_o;
  logic             reg_write_enable_o;
  logic             mem_write_enable_o;

  // TPU sequencing
  logic             tpu_start_o;
  logic             tpu_write_enable_A;
  logic             tpu_write_enable_B;
  logic             tpu_write_enable_C;
  logic [ROW_W-1:0] tpu_row_o;
  logic             tpu_busy_o;
  logic             tpu_timeout_o;

  modport slave (
    input  valid_i, op_i, stall_i, flush_i, tpu_done_i,
    output ready_o, valid_o, imm_sel_o, alu_op_o, branch_type_o, wb_sel_o,
           reg_write_enable_o, mem_write_enable_o, tpu_start_o,
           tpu_write_enable_A, tpu_write_enable_B, tpu_write_enable_C,
           tpu_row_o, tpu_busy_o, tpu_timeout_o
  );

  modport master (
    output valid_i, op_i, stall_i, flush_i, tpu_done_i,
    input  ready_o, valid_o, imm_sel_o, alu_op_o, branch_type_o, wb_sel_o,
           reg_write_enable_o, mem_write_enable_o, tpu_start_o,
           tpu_write_enable_A, tpu_write_enable_B, tpu_write_enable_C,
           tpu_row_o, tpu_busy_o, tpu_timeout_o
  );
endinterface

// File: rtl/control_seq.sv
// control_seq: registered opcode decode with a TPU load-burst / matmul sequencer.
// Define CONTROL_SEQ_TIMEOUT_EN to add the TMO_W-bit tpu_done_i timeout.

module control_seq #(
  parameter int OP_W    = 7,
  parameter int TPU_DIM = 8,
  parameter int TMO_W   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  control_seq_if.slave bus
);

  localparam int               ROW_W    = $clog2(TPU_DIM);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TPU_DIM - 1);

  typedef enum logic [1:0] {IDLE, BURST, WAIT_DONE} state_e;
  typedef enum logic [1:0] {MAT_NONE, MAT_A, MAT_B, MAT_C} mat_e;
  typedef logic [TMO_W-1:0] tmo_t;

  typedef struct packed {
    logic       imm_sel;
    logic [3:0] alu_op;
    logic [1:0] branch_type;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       mem_we;
    logic       is_matmul;
    mat_e       mat;
  } dec_t;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             valid_q;
  logic             start_q;
  dec_t             dec_q, dec;

  logic [6:0] op7;
  logic       op_hi_zero;
  logic       is_alu, is_imm, is_lw, is_sw, is_br, is_tpu, is_jmp, legal;
  logic       ready, accept, burst_en;

  // ---------------------------------------------------------------------------
  // Combinational decode of the presented opcode
  // ---------------------------------------------------------------------------
  assign op7        = bus.op_i[6:0];
  assign op_hi_zero = ((bus.op_i >> 7) == '0);

  assign is_alu = (op7 >= 7'h01) && (op7 <= 7'h0A);
  assign is_imm = (op7 == 7'h11) || ((op7 >= 7'h13) && (op7 <= 7'h19)) || (op7 == 7'h1B);
  assign is_lw  = (op7 == 7'h20);
  assign is_sw  = (op7 == 7'h21);
  assign is_br  = (op7 >= 7'h3C) && (op7 <= 7'h3F);
  assign is_tpu = (op7 >= 7'h50) && (op7 <= 7'h54);
  assign is_jmp = (op7[6:1] == 6'h3F);
  assign legal  = op_hi_zero && (is_alu || is_imm || is_lw || is_sw || is_br || is_tpu || is_jmp);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec = '0;
    if (legal) begin
      dec.imm_sel   = op7[4] ^ op7[5];
      dec.wb_sel    = {op7[6:4] == 3'b101, op7[6:4] == 3'b010};
      dec.alu_op    = (op7[6:4] == 3'b010) ? 4'h1 : op7[3:0];
      if (op7[6:4] == 3'b011)
        dec.branch_type = 2'b01;
      else if (&op7[6:1])
        dec.branch_type = {1'b1, op7[0]};
      else
        dec.branch_type = 2'b00;
      // racc returns the accumulator through the TPU writeback path
      dec.reg_we    = is_alu || is_imm || is_lw || (op7 == 7'h54);
      dec.mem_we    = is_sw;
      dec.is_matmul = (op7 == 7'h50);
      case (op7)
        7'h51:   dec.mat = MAT_A;
        7'h52:   dec.mat = MAT_B;
        7'h53:   dec.mat = MAT_C;
        default: dec.mat = MAT_NONE;
      endcase
    end
  end

  // A flush in the same cycle drops the presented opcode outright
  assign ready  = (state_q == IDLE) && !bus.stall_i;
  assign accept = bus.valid_i && ready && !bus.flush_i;

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
`ifdef CONTROL_SEQ_TIMEOUT_EN
  tmo_t tmo_cnt_q, tmo_cnt_d;
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
`ifdef CONTROL_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec.mat != MAT_NONE) begin
            state_d = BURST;
            row_d   = '0;
          end else if (dec.is_matmul) begin
            state_d = WAIT_DONE;
          end
        end
      end
      BURST: begin
        if (bus.flush_i) begin
          state_d = IDLE;
          row_d   = '0;
        end else if (!bus.stall_i) begin
          if (row_q == ROW_LAST) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      WAIT_DONE: begin
        // The start cycle itself never counts as completion
        if (!start_q && bus.tpu_done_i) begin
          state_d = IDLE;
        end
`ifdef CONTROL_SEQ_TIMEOUT_EN
        else if (!start_q) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (&tmo_cnt_d) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef CONTROL_SEQ_TIMEOUT_EN
    if (state_d != WAIT_DONE) tmo_cnt_d = '0;
`endif
  end

  // ---------------------------------------------------------------------------
  // State and decode registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      start_q <= accept && dec.is_matmul;
      if (bus.flush_i)
        valid_q <= 1'b0;
      else if (!(bus.stall_i && valid_q))
        valid_q <= accept;
      if (accept) dec_q <= dec;
    end
  end

`ifdef CONTROL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.tpu_timeout_o = timeout_q;
`else
  assign bus.tpu_timeout_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign burst_en = (state_q == BURST) && !bus.stall_i && !bus.flush_i;

  assign bus.ready_o            = ready;
  assign bus.valid_o            = valid_q;
  assign bus.imm_sel_o          = dec_q.imm_sel;
  assign bus.alu_op_o           = dec_q.alu_op;
  assign bus.branch_type_o      = dec_q.branch_type;
  assign bus.wb_sel_o           = dec_q.wb_sel;
  assign bus.reg_write_enable_o = valid_q && dec_q.reg_we;
  assign bus.mem_write_enable_o = valid_q && dec_q.mem_we;
  assign bus.tpu_start_o        = valid_q && start_q;
  assign bus.tpu_write_enable_A = burst_en && (dec_q.mat == MAT_A);
  assign bus.tpu_write_enable_B = burst_en && (dec_q.mat == MAT_B);
  assign bus.tpu_write_enable_C = burst_en && (dec_q.mat == MAT_C);
  assign bus.tpu_row_o          = row_q;
  assign bus.tpu_busy_o         = (state_q != IDLE);

endmodule
